mul4_fitness_scorer: RTL and testbench

- Sequential evaluation harness that sits directly upstream and downstream of an evolved mul4_vector candidate.
- Generates pseudo-random operand vectors and drives them into the candidate's a1/a0/b1/b0 inputs.
- Samples the candidate's y3..y0 outputs and scores them against a golden 32x32 product.
- Reports a per-bit match score and an exact-match count; these form the fitness value returned to the GE engine.

---
 rtl/mul4_fitness_scorer.sv | 158 +++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for an evolved 32x32 multiplier candidate.
// It drives pseudo-random operands into the candidate, compares the candidate's
// 64-bit result with a registered golden product, and accumulates a per-bit
// match score and an exact-match count for the run.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; all registers are at their reset value
// DRIVE | operands stable; golden product of the current operands is registered
// CHECK | candidate sampled and scored; both LFSRs advance to the next vector
// DONE  | scores held and valid; operands frozen; start begins a new run
module mul4_fitness_scorer #(
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED_B_XOR  = 32'h5A5A_5A5A,
    parameter int          SCORE_W     = $clog2(NUM_VECTORS*64+1),
    parameter int          CNT_W       = $clog2(NUM_VECTORS+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        seed,
    input  logic [15:0]        cand_y3,
    input  logic [15:0]        cand_y2,
    input  logic [15:0]        cand_y1,
    input  logic [15:0]        cand_y0,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] bit_score,
    output logic [CNT_W-1:0]   exact_count,
    output logic [CNT_W-1:0]   vec_idx
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_a_q, lfsr_a_d;
    logic [31:0]        lfsr_b_q, lfsr_b_d;
    logic [63:0]        prod_q, prod_d;
    logic [SCORE_W-1:0] bit_score_q, bit_score_d;
    logic [CNT_W-1:0]   exact_q, exact_d;
    logic [CNT_W-1:0]   vec_idx_q, vec_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0] seed_a, seed_b, seed_b_raw;
    logic [63:0] match;
    logic [6:0]  match_ones;

    // Galois LFSR, x^32+x^22+x^2+x+1, shifting right
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed becomes 1
    assign seed_b_raw = seed ^ SEED_B_XOR;
    assign seed_a     = (seed == 32'h0)       ? 32'h1 : seed;
    assign seed_b     = (seed_b_raw == 32'h0) ? 32'h1 : seed_b_raw;

    assign match = ~({cand_y3, cand_y2, cand_y1, cand_y0} ^ prod_q);

    // Population count of matching result bits for the vector under test
    always_comb begin
        match_ones = '0;
        for (int i = 0; i < 64; i++) begin
            match_ones = match_ones + 7'(match[i]);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        prod_d      = prod_q;
        bit_score_d = bit_score_q;
        exact_d     = exact_q;
        vec_idx_d   = vec_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_a_d    = seed_a;
                    lfsr_b_d    = seed_b;
                    bit_score_d = '0;
                    exact_d     = '0;
                    vec_idx_d   = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    state_d     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                prod_d  = 64'(lfsr_a_q) * 64'(lfsr_b_q);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                bit_score_d = bit_score_q + SCORE_W'(match_ones);
                if (&match) begin
                    exact_d = exact_q + CNT_W'(1);
                end
                lfsr_a_d = lfsr_step(lfsr_a_q);
                lfsr_b_d = lfsr_step(lfsr_b_q);
                if (vec_idx_q == CNT_W'(NUM_VECTORS-1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + CNT_W'(1);
                    state_d   = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts a run with nothing retained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_a_q    <= '0;
            lfsr_b_q    <= '0;
            prod_q      <= '0;
            bit_score_q <= '0;
            exact_q     <= '0;
            vec_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            prod_q      <= prod_d;
            bit_score_q <= bit_score_d;
            exact_q     <= exact_d;
            vec_idx_q   <= vec_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a1          = lfsr_a_q[31:16];
    assign a0          = lfsr_a_q[15:0];
    assign b1          = lfsr_b_q[31:16];
    assign b0          = lfsr_b_q[15:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_score   = bit_score_q;
    assign exact_count = exact_q;
    assign vec_idx     = vec_idx_q;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer. The bench plays the candidate:
// an ideal multiplier, optionally with y3 inverted or y0 stuck at zero.
module tb_mul4_fitness_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] cand_y3, cand_y2, cand_y1, cand_y0;
    logic [15:0] a1, a0, b1, b0;
    logic        busy, done;
    logic [10:0] bit_score;
    logic [4:0]  exact_count, vec_idx;

    int          mode = 0;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] gold;
    int          m_score, m_exact;

    mul4_fitness_scorer dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .cand_y3(cand_y3), .cand_y2(cand_y2), .cand_y1(cand_y1), .cand_y0(cand_y0),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .busy(busy), .done(done), .bit_score(bit_score),
        .exact_count(exact_count), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    // Candidate under test: ideal product with a selectable fault
    assign gold    = 64'({a1, a0}) * 64'({b1, b0});
    assign cand_y3 = (mode == 1) ? ~gold[63:48] : gold[63:48];
    assign cand_y2 = gold[47:32];
    assign cand_y1 = gold[31:16];
    assign cand_y0 = (mode == 2) ? 16'h0000 : gold[15:0];

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_seed_a(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] ref_seed_b(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ 32'h5A5A_5A5A;
        return (t == 32'h0) ? 32'h1 : t;
    endfunction

    // Expected scores with y0 stuck at zero: y3..y1 always match,
    // y0 matches wherever the product's low 16 bits are zero
    task automatic model_y0_stuck(input logic [31:0] sd, output int score, output int exact);
        logic [31:0] a, b;
        logic [63:0] p;
        a = ref_seed_a(sd);
        b = ref_seed_b(sd);
        score = 0;
        exact = 0;
        for (int v = 0; v < 16; v++) begin
            p = 64'(a) * 64'(b);
            score += 48 + (16 - $countones(p[15:0]));
            if (p[15:0] == 16'h0) exact++;
            a = ref_step(a);
            b = ref_step(b);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from start pulse to done; restart_at>0 pulses start mid-run
    task automatic do_run(input string tag, input logic [31:0] sd, input int restart_at,
                          input int exp_score, input int exp_exact);
        int          n;
        int          busy_gaps;
        logic [31:0] ea, eb;
        ea = ref_seed_a(sd);
        eb = ref_seed_b(sd);
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed  = 32'hDEAD_BEEF;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_done_e0"}, done, 0);
        chk({tag, "_ops_e0"}, {a1, a0, b1, b0}, {ea, eb});
        n = 0;
        busy_gaps = 0;
        while (!done && n < 100) begin
            if (restart_at > 0 && n == restart_at - 1) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
            if (!done && !busy) busy_gaps++;
            if (n == 2) begin
                chk({tag, "_vec_idx_e2"}, vec_idx, 1);
                chk({tag, "_ops_vec1"}, {a1, a0, b1, b0}, {ref_step(ea), ref_step(eb)});
            end
        end
        chk({tag, "_done_cycles"}, n, 32);
        chk({tag, "_busy_gaps"}, busy_gaps, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_vec_idx_end"}, vec_idx, 15);
        chk({tag, "_bit_score"}, bit_score, exp_score);
        chk({tag, "_exact_count"}, exact_count, exp_exact);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_outputs", {busy, done, bit_score, exact_count, vec_idx}, 0);
        chk("rst_operands", {a1, a0, b1, b0}, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_start", {busy, done}, 0);

        // Ideal candidate
        mode = 0;
        do_run("ideal", 32'h1234_5678, 0, 1024, 16);
        chk("ideal_a_hi", a1 === 16'h1234 ? 1'b0 : 1'b1, 1);

        // y3 inverted, with start pulsed at the 5th cycle of the run
        mode = 1;
        do_run("inv_y3", 32'h1234_5678, 5, 768, 0);

        // y0 stuck at zero with zero seed
        mode = 2;
        model_y0_stuck(32'h0, m_score, m_exact);
        do_run("y0_zero", 32'h0, 0, m_score, m_exact);
        chk("y0_zero_ops_vals", {a1, a0, b1, b0} == 64'h0000_0001_5A5A_5A5A, 0);

        // Restart from DONE with the same seed must repeat the run exactly
        do_run("repeat", 32'h0, 0, m_score, m_exact);

        // Abort with rst at the 10th cycle, then a full run
        mode  = 0;
        seed  = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("pre_abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, bit_score, exact_count, vec_idx}, 0);
        chk("abort_operands", {a1, a0, b1, b0}, 0);
        tick();
        rst = 1'b0;
        tick();
        do_run("after_abort", 32'h1234_5678, 0, 1024, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
